srlzr_ctrl: RTL and testbench

//  Frame controller for the transceiver serializer path. Accepts parallel words on a

---
 rtl/srlzr_pkg.sv | 19 +
 rtl/piso_shift.sv | 42 ++++
 rtl/srlzr_ctrl.sv | 163 ++++++++++++++++
 tb/tb_srlzr_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srlzr_pkg.sv
// Shared types and helpers for the serializer frame controller.
//   state_e   : controller FSM states (idle, load PISO, shift bits, idle gap)
//   cnt_width : counter width able to hold 0..n-1, never narrower than one bit
package srlzr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StGap
  } state_e;

  // The bit counter uses cnt_width(DATA_WIDTH) and the gap counter uses
  // cnt_width(GAP_CYCLES + 1). With GAP_CYCLES = 0 the counter still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high clear
//   load_i     : capture d_i (wins over shift_en_i)
//   shift_en_i : advance one bit towards the serial output, zero-filling
//   d_i        : parallel word
//   q_o        : current serial bit, straight from the register
module piso_shift #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  shift_en_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic                  q_o
);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = d_i;
    end else if (shift_en_i) begin
      // Zero fill: once a whole word has been shifted out the output idles at 0.
      sr_d = MSB_FIRST ? {sr_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, sr_q[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = MSB_FIRST ? sr_q[DATA_WIDTH-1] : sr_q[0];

endmodule

// File: rtl/srlzr_ctrl.sv
// Serializer frame controller: one-word holding buffer on a valid/ready input,
// FSM sequencing an embedded PISO, registered serial outputs and a frame counter.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   s_valid_i   : upstream word valid
//   s_ready_o   : holding buffer empty (low during reset)
//   s_data_i    : upstream word
//   ser_out_o   : serial data, 0 whenever ser_valid_o is low
//   ser_valid_o : high on each cycle carrying a data bit
//   sof_o       : pulse with first bit of a frame
//   eof_o       : pulse with last bit of a frame
//   busy_o      : FSM active or buffer full
//   frame_cnt_o : completed frames, wraps modulo 2^CNT_WIDTH
module srlzr_ctrl
  import srlzr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  ser_out_o,
  output logic                  ser_valid_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  frame_cnt_o
);

  localparam int unsigned BitCntW = cnt_width(DATA_WIDTH);
  localparam int unsigned GapCntW = cnt_width(GAP_CYCLES + 1);
  localparam logic [BitCntW-1:0] BitLast = BitCntW'(DATA_WIDTH - 1);
  localparam logic [GapCntW-1:0] GapLast = GapCntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GapCntW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  ready_q, ready_d;
  logic                  ser_valid_q, ser_valid_d;
  logic                  sof_q, sof_d;
  logic                  eof_q, eof_d;
  logic                  busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic                  piso_load, piso_shift_en, piso_q;
  logic                  accept;

  // ready_q mirrors !buf_full_q except that it is held low through reset.
  assign accept = s_valid_i & ready_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    piso_load     = 1'b0;
    piso_shift_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (buf_full_q) state_d = StLoad;
      end
      StLoad: begin
        piso_load  = 1'b1;
        buf_full_d = 1'b0;
        bit_cnt_d  = '0;
        state_d    = StShift;
      end
      StShift: begin
        // Shifting on the last bit as well drains the PISO to all zeros.
        piso_shift_en = 1'b1;
        if (bit_cnt_q == BitLast) begin
          if (GAP_CYCLES > 0) begin
            gap_cnt_d = '0;
            state_d   = StGap;
          end else begin
            state_d = buf_full_q ? StLoad : StIdle;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = buf_full_q ? StLoad : StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // After the case so a capture can never be lost to the LOAD clear.
    if (accept) begin
      buf_d      = s_data_i;
      buf_full_d = 1'b1;
    end

    // Output registers are fed from next-state so they line up with the PISO bit.
    ready_d     = ~buf_full_d;
    ser_valid_d = (state_d == StShift);
    sof_d       = ser_valid_d && (bit_cnt_d == '0);
    eof_d       = ser_valid_d && (bit_cnt_d == BitLast);
    busy_d      = (state_d != StIdle) || buf_full_d;
    frame_cnt_d = eof_q ? frame_cnt_q + 1'b1 : frame_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      ready_q     <= 1'b0;
      ser_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      ready_q     <= ready_d;
      ser_valid_q <= ser_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  piso_shift #(
    .DATA_WIDTH(DATA_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (piso_load),
    .shift_en_i(piso_shift_en),
    .d_i       (buf_q),
    .q_o       (piso_q)
  );

  assign s_ready_o   = ready_q;
  assign ser_out_o   = piso_q;
  assign ser_valid_o = ser_valid_q;
  assign sof_o       = sof_q;
  assign eof_o       = eof_q;
  assign busy_o      = busy_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_srlzr_ctrl.sv
// Directed bench for srlzr_ctrl. Four instances share clock, reset and input
// stimulus: default, LSB-first, zero gap, and a 4-bit frame counter.
module tb_srlzr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic [3:0] rdy, sout, sval, sof, eof, busy;
  logic [15:0] fc0, fc1, fc2;
  logic [3:0]  fc3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  srlzr_ctrl u_dut0 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(rdy[0]), .s_data_i(s_data),
    .ser_out_o(sout[0]), .ser_valid_o(sval[0]), .sof_o(sof[0]), .eof_o(eof[0]),
    .busy_o(busy[0]), .frame_cnt_o(fc0)
  );

  srlzr_ctrl #(.MSB_FIRST(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(rdy[1]), .s_data_i(s_data),
    .ser_out_o(sout[1]), .ser_valid_o(sval[1]), .sof_o(sof[1]), .eof_o(eof[1]),
    .busy_o(busy[1]), .frame_cnt_o(fc1)
  );

  srlzr_ctrl #(.GAP_CYCLES(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(rdy[2]), .s_data_i(s_data),
    .ser_out_o(sout[2]), .ser_valid_o(sval[2]), .sof_o(sof[2]), .eof_o(eof[2]),
    .busy_o(busy[2]), .frame_cnt_o(fc2)
  );

  srlzr_ctrl #(.CNT_WIDTH(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(rdy[3]), .s_data_i(s_data),
    .ser_out_o(sout[3]), .ser_valid_o(sval[3]), .sof_o(sof[3]), .eof_o(eof[3]),
    .busy_o(busy[3]), .frame_cnt_o(fc3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    step();
    step();
    checks++;
    if ({rdy, sout, sval, sof, eof, busy} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 000000", {rdy, sout, sval, sof, eof, busy});
    end
    checks++;
    if ((fc0 | fc1 | fc2) !== 16'h0 || fc3 !== 4'h0) begin
      errors++;
      $display("FAIL reset_frame_cnt got %h %h %h %h exp 0", fc0, fc1, fc2, fc3);
    end
    rst = 1'b0;
    step();
    checks++;
    if (rdy !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready_after_release got %b exp 1111", rdy);
    end
  endtask

  // 8'hA5 MSB first: 1,0,1,0,0,1,0,1 on cycles t+2..t+9.
  task automatic test_single_frame();
    logic [0:7] exp_seq;
    logic       ev, eo;
    exp_seq = 8'b10100101;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    step();
    s_valid = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      ev = (k >= 2 && k <= 9);
      eo = 1'b0;
      if (ev) eo = exp_seq[k-2];
      checks++;
      if (sval[0] !== ev || sout[0] !== eo) begin
        errors++;
        $display("FAIL single_bit k=%0d got v=%b d=%b exp v=%b d=%b", k, sval[0], sout[0], ev,
                 eo);
      end
      checks++;
      if (sof[0] !== (k == 2) || eof[0] !== (k == 9)) begin
        errors++;
        $display("FAIL single_sof_eof k=%0d got %b%b exp %b%b", k, sof[0], eof[0], k == 2,
                 k == 9);
      end
      checks++;
      if (busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL single_busy k=%0d got %b exp 1", k, busy[0]);
      end
      if (k == 9 || k == 10) begin
        checks++;
        if (fc0 !== ((k == 10) ? 16'd1 : 16'd0)) begin
          errors++;
          $display("FAIL single_frame_cnt k=%0d got %0d exp %0d", k, fc0, (k == 10) ? 1 : 0);
        end
      end
      step();
    end
    step();
    step();
    checks++;
    if (busy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_idle got busy=%b rdy=%b exp busy=0 rdy=1", busy[0], rdy[0]);
    end
  endtask

  // 8'hFF then 8'h00 held valid; second word taken at t+3, LOAD at t+12.
  task automatic test_back_to_back();
    logic [0:21] ev, er, eo;
    ev = 22'b0011111111000111111110;
    er = 22'b0010000000000111111111;
    eo = 22'b0011111111000000000000;
    do_reset();
    s_valid = 1'b1;
    s_data  = 8'hFF;
    step();
    s_data = 8'h00;
    for (int k = 0; k <= 21; k++) begin
      if (k == 3) s_valid = 1'b0;
      checks++;
      if (sval[0] !== ev[k] || sout[0] !== eo[k]) begin
        errors++;
        $display("FAIL b2b_bit k=%0d got v=%b d=%b exp v=%b d=%b", k, sval[0], sout[0], ev[k],
                 eo[k]);
      end
      checks++;
      if (rdy[0] !== er[k]) begin
        errors++;
        $display("FAIL b2b_ready k=%0d got %b exp %b", k, rdy[0], er[k]);
      end
      checks++;
      if (sof[0] !== (k == 2 || k == 13) || eof[0] !== (k == 9 || k == 20)) begin
        errors++;
        $display("FAIL b2b_sof_eof k=%0d got %b%b", k, sof[0], eof[0]);
      end
      step();
    end
    checks++;
    if (fc0 !== 16'd2) begin
      errors++;
      $display("FAIL b2b_frame_cnt got %0d exp 2", fc0);
    end
  endtask

  // Runs straight after test_back_to_back so frame_cnt starts at 2.
  task automatic test_reset_mid_frame();
    int v_cnt;
    int e_cnt;
    checks++;
    if (fc0 !== 16'd2) begin
      errors++;
      $display("FAIL midrst_pre_cnt got %0d exp 2", fc0);
    end
    s_valid = 1'b1;
    s_data  = 8'hA5;
    step();
    s_data = 8'hC3;
    step();
    step();
    step();
    s_valid = 1'b0;
    checks++;
    if (rdy[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_buffered got rdy=%b busy=%b exp rdy=0 busy=1", rdy[0], busy[0]);
    end
    step();
    step();
    step();
    // Bit 4 of 8'hA5 sent MSB first is 0.
    checks++;
    if (sval[0] !== 1'b1 || sout[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_bit4 got v=%b d=%b exp v=1 d=0", sval[0], sout[0]);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({sval[0], sout[0], eof[0], busy[0], rdy[0]} !== 5'b0 || fc0 !== 16'd0) begin
      errors++;
      $display("FAIL midrst_cleared got v=%b d=%b eof=%b busy=%b rdy=%b cnt=%0d exp all 0",
               sval[0], sout[0], eof[0], busy[0], rdy[0], fc0);
    end
    rst = 1'b0;
    step();
    checks++;
    if (rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready got %b exp 1", rdy[0]);
    end
    v_cnt = 0;
    e_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (sval[0] === 1'b1) v_cnt++;
      if (eof[0] === 1'b1) e_cnt++;
      step();
    end
    checks++;
    if (v_cnt != 0 || e_cnt != 0 || fc0 !== 16'd0) begin
      errors++;
      $display("FAIL midrst_discard got valid_cycles=%0d eofs=%0d cnt=%0d exp 0 0 0", v_cnt,
               e_cnt, fc0);
    end
  endtask

  // 8'h01: LSB-first instance sends 1 first, MSB-first instance sends it last.
  task automatic test_lsb_first();
    do_reset();
    s_valid = 1'b1;
    s_data  = 8'h01;
    step();
    s_valid = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      checks++;
      if (sval[1] !== (k >= 2 && k <= 9) || sout[1] !== (k == 2)) begin
        errors++;
        $display("FAIL lsb_bit k=%0d got v=%b d=%b exp v=%b d=%b", k, sval[1], sout[1],
                 k >= 2 && k <= 9, k == 2);
      end
      checks++;
      if (sout[0] !== (k == 9)) begin
        errors++;
        $display("FAIL msb_ref_bit k=%0d got %b exp %b", k, sout[0], k == 9);
      end
      step();
    end
  endtask

  // Zero gap: ser_valid low only for the LOAD cycle between frames.
  task automatic test_no_gap();
    logic [0:19] ev, er, eo;
    ev = 20'b00111111110111111110;
    er = 20'b00100000000111111111;
    eo = 20'b00111111110000000000;
    do_reset();
    s_valid = 1'b1;
    s_data  = 8'hFF;
    step();
    s_data = 8'h00;
    for (int k = 0; k <= 19; k++) begin
      if (k == 3) s_valid = 1'b0;
      checks++;
      if (sval[2] !== ev[k] || sout[2] !== eo[k] || rdy[2] !== er[k]) begin
        errors++;
        $display("FAIL nogap k=%0d got v=%b d=%b r=%b exp v=%b d=%b r=%b", k, sval[2], sout[2],
                 rdy[2], ev[k], eo[k], er[k]);
      end
      step();
    end
    checks++;
    if (fc2 !== 16'd2) begin
      errors++;
      $display("FAIL nogap_frame_cnt got %0d exp 2", fc2);
    end
  endtask

  // 4-bit counter over 16 frames: 1..15 then 0.
  task automatic test_cnt_wrap();
    logic [3:0] exp_cnt;
    int         acc, n_eof, budget;
    logic       pending, prev_eof;
    do_reset();
    exp_cnt  = 4'd0;
    acc      = 0;
    n_eof    = 0;
    budget   = 0;
    prev_eof = 1'b0;
    s_valid  = 1'b1;
    s_data   = 8'h5A;
    while (n_eof < 16 && budget < 400) begin
      pending = s_valid & rdy[3];
      step();
      budget++;
      if (pending) acc++;
      if (acc >= 16) s_valid = 1'b0;
      if (prev_eof) begin
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (fc3 !== exp_cnt) begin
          errors++;
          $display("FAIL wrap_cnt frame=%0d got %0d exp %0d", n_eof, fc3, exp_cnt);
        end
      end
      if (eof[3] === 1'b1) n_eof++;
      prev_eof = eof[3];
    end
    s_valid = 1'b0;
    checks++;
    if (n_eof != 16) begin
      errors++;
      $display("FAIL wrap_frames got %0d exp 16 (cycle budget)", n_eof);
    end
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (fc3 !== 4'd0 || busy[3] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end got cnt=%0d busy=%b exp cnt=0 busy=0", fc3, busy[3]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_lsb_first();
    test_no_gap();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got no finish exp finish");
    $fatal(1, "watchdog");
  end

endmodule
